// File: rtl/spi_regmap_pkg.sv
// Shared command-field positions, FSM states and default map constants for the SPI register-map slave.
package spi_regmap_pkg;

  localparam int RW_BIT = 7;
  localparam int MS_BIT = 6;
  localparam int DA_BIT = 3;

  localparam logic [5:0] DEF_WHO_AM_I_ADDR = 6'h0F;
  localparam logic [7:0] DEF_WHO_AM_I_VAL  = 8'h33;
  localparam logic [5:0] DEF_STATUS_ADDR   = 6'h27;
  localparam logic [5:0] DEF_OUT_BASE      = 6'h28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with registered rise/fall pulses; level after STAGES clk, edge pulse one clk later.
// No flow control: pulses are single-cycle and must be consumed when they occur.
module spi_edge_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign lvl  = sync_q[STAGES-1];
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/spi_regmap_slave.sv
// Oversampled SPI slave register map with tear-free sample channels and SPI read/write event strobes.
// State updates land one clk after each detected sck/csn edge; no backpressure, the SPI master sets the pace.
module spi_regmap_slave
  import spi_regmap_pkg::*;
#(
  parameter int                NREGS         = 64,
  parameter int                ADDR_W        = 6,
  parameter logic [ADDR_W-1:0] WHO_AM_I_ADDR = DEF_WHO_AM_I_ADDR,
  parameter logic [7:0]        WHO_AM_I_VAL  = DEF_WHO_AM_I_VAL,
  parameter logic [ADDR_W-1:0] STATUS_ADDR   = DEF_STATUS_ADDR,
  parameter int                NCH           = 3,
  parameter logic [ADDR_W-1:0] OUT_BASE      = DEF_OUT_BASE,
  parameter int                SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sck,
  input  logic              csn,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              sample_valid,
  input  logic [NCH*16-1:0] sample_data,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              rd_evt,
  output logic [ADDR_W-1:0] rd_evt_addr,
  output logic              wr_evt,
  output logic [ADDR_W-1:0] wr_evt_addr,
  output logic [7:0]        wr_evt_data
);

  localparam int                OUT_LO   = int'(OUT_BASE);
  localparam int                OUT_HI   = OUT_LO + 2 * NCH - 1;
  localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_HI);

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic csn_lvl, csn_rise, csn_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(clk), .resetn(resetn), .d(sck),
    .lvl(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk(clk), .resetn(resetn), .d(csn),
    .lvl(csn_lvl), .rise(csn_rise), .fall(csn_fall)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) mosi_sync_q <= '0;
    else         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [7:0]        shin_q, shin_d;
  logic [7:0]        shout_q, shout_d;
  logic              rw_q, rw_d;
  logic              ms_q, ms_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        regs_q [NREGS];
  logic [7:0]        regs_d [NREGS];
  logic              da_q, da_d;
  logic              pend_q, pend_d;
  logic [NCH*16-1:0] pend_dat_q, pend_dat_d;
  logic              rd_evt_q, rd_evt_d;
  logic [ADDR_W-1:0] rd_evt_addr_q, rd_evt_addr_d;
  logic              wr_evt_q, wr_evt_d;
  logic [ADDR_W-1:0] wr_evt_addr_q, wr_evt_addr_d;
  logic [7:0]        wr_evt_data_q, wr_evt_data_d;

  logic [7:0]        shin_nx;
  logic [ADDR_W-1:0] nxt_addr, fetch_addr;
  logic              fetch, spi_wr, ld, da_set;
  logic [NCH*16-1:0] ld_dat;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (int'(a) == NREGS - 1) ? '0 : a + 1'b1;
  endfunction

  function automatic logic is_writable(input logic [ADDR_W-1:0] a);
    int ia = int'(a);
    return (ia < NREGS) && (a != WHO_AM_I_ADDR) && (a != STATUS_ADDR) &&
           !((ia >= OUT_LO) && (ia <= OUT_HI));
  endfunction

  // STATUS is synthesised from the DA flag rather than stored.
  function automatic logic [7:0] rd_val(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = '0;
    if (int'(a) >= NREGS)      v = '0;
    else if (a == STATUS_ADDR) v[DA_BIT] = da_q;
    else                       v = regs_q[a];
    return v;
  endfunction

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    shin_d        = shin_q;
    shout_d       = shout_q;
    rw_d          = rw_q;
    ms_d          = ms_q;
    addr_d        = addr_q;
    regs_d        = regs_q;
    da_d          = da_q;
    pend_d        = pend_q;
    pend_dat_d    = pend_dat_q;
    rd_evt_d      = 1'b0;
    rd_evt_addr_d = rd_evt_addr_q;
    wr_evt_d      = 1'b0;
    wr_evt_addr_d = wr_evt_addr_q;
    wr_evt_data_d = wr_evt_data_q;
    shin_nx       = {shin_q[6:0], mosi_s};
    nxt_addr      = ms_q ? addr_inc(addr_q) : addr_q;
    fetch         = 1'b0;
    fetch_addr    = addr_q;
    spi_wr        = 1'b0;
    ld            = 1'b0;
    ld_dat        = pend_dat_q;
    da_set        = 1'b0;

    if (csn_rise) begin
      state_d  = ST_IDLE;
      bitcnt_d = '0;
    end else if (csn_fall) begin
      state_d  = ST_CMD;
      bitcnt_d = '0;
      shin_d   = '0;
    end else if (state_q != ST_IDLE && sck_rise) begin
      bitcnt_d = bitcnt_q + 3'd1;
      shin_d   = shin_nx;
      if (bitcnt_q == 3'd7) begin
        if (state_q == ST_CMD) begin
          rw_d    = shin_nx[RW_BIT];
          ms_d    = shin_nx[MS_BIT];
          addr_d  = shin_nx[ADDR_W-1:0];
          state_d = ST_DATA;
          if (shin_nx[RW_BIT]) begin
            fetch      = 1'b1;
            fetch_addr = shin_nx[ADDR_W-1:0];
          end
        end else if (rw_q) begin
          addr_d     = nxt_addr;
          fetch      = 1'b1;
          fetch_addr = nxt_addr;
        end else begin
          spi_wr        = 1'b1;
          wr_evt_d      = 1'b1;
          wr_evt_addr_d = addr_q;
          wr_evt_data_d = shin_nx;
          addr_d        = nxt_addr;
        end
      end
    end else if (state_q == ST_DATA && rw_q && sck_fall && bitcnt_q != 3'd0) begin
      shout_d = {shout_q[6:0], 1'b0};
    end

    if (fetch) begin
      shout_d       = rd_val(fetch_addr);
      rd_evt_d      = 1'b1;
      rd_evt_addr_d = fetch_addr;
      if (fetch_addr == OUT_LAST) da_d = 1'b0;
    end

    // A direct load also drops any older pending sample so the latest always wins.
    if (csn_rise && pend_q) begin
      ld     = 1'b1;
      pend_d = 1'b0;
    end
    if (sample_valid) begin
      if (csn_lvl) begin
        ld     = 1'b1;
        ld_dat = sample_data;
        pend_d = 1'b0;
      end else begin
        pend_d     = 1'b1;
        pend_dat_d = sample_data;
      end
    end
    if (ld) begin
      da_set = 1'b1;
      for (int k = 0; k < NCH; k++) begin
        regs_d[ADDR_W'(OUT_LO + 2 * k)]     = ld_dat[16*k +: 8];
        regs_d[ADDR_W'(OUT_LO + 2 * k + 1)] = ld_dat[16*k+8 +: 8];
      end
    end
    if (da_set) da_d = 1'b1;

    if (host_we && is_writable(host_addr) && !(spi_wr && host_addr == addr_q))
      regs_d[host_addr] = host_wdata;
    if (spi_wr && is_writable(addr_q))
      regs_d[addr_q] = shin_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      bitcnt_q      <= '0;
      shin_q        <= '0;
      shout_q       <= '0;
      rw_q          <= 1'b0;
      ms_q          <= 1'b0;
      addr_q        <= '0;
      da_q          <= 1'b0;
      pend_q        <= 1'b0;
      pend_dat_q    <= '0;
      rd_evt_q      <= 1'b0;
      rd_evt_addr_q <= '0;
      wr_evt_q      <= 1'b0;
      wr_evt_addr_q <= '0;
      wr_evt_data_q <= '0;
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == int'(WHO_AM_I_ADDR)) ? WHO_AM_I_VAL : 8'h00;
    end else begin
      state_q       <= state_d;
      bitcnt_q      <= bitcnt_d;
      shin_q        <= shin_d;
      shout_q       <= shout_d;
      rw_q          <= rw_d;
      ms_q          <= ms_d;
      addr_q        <= addr_d;
      da_q          <= da_d;
      pend_q        <= pend_d;
      pend_dat_q    <= pend_dat_d;
      rd_evt_q      <= rd_evt_d;
      rd_evt_addr_q <= rd_evt_addr_d;
      wr_evt_q      <= wr_evt_d;
      wr_evt_addr_q <= wr_evt_addr_d;
      wr_evt_data_q <= wr_evt_data_d;
      regs_q        <= regs_d;
    end
  end

  always_comb host_rdata = rd_val(host_addr);

  assign miso        = (!csn_lvl && state_q == ST_DATA && rw_q) ? shout_q[7] : 1'b0;
  assign miso_oe     = ~csn_lvl;
  assign rd_evt      = rd_evt_q;
  assign rd_evt_addr = rd_evt_addr_q;
  assign wr_evt      = wr_evt_q;
  assign wr_evt_addr = wr_evt_addr_q;
  assign wr_evt_data = wr_evt_data_q;

endmodule
